jtag_tap_ctrl: RTL and testbench

IEEE 1149.1-style TAP controller for the JTAG core. It runs the 16-state TAP state machine from TMS and owns the 4-bit instruction register and the 1-bit bypass register. It decodes the active instruction into the per-register select lines, and drives the capture, shift and update strobes that sequence the data-register block. It also multiplexes all serial returns onto TDO.

---
 rtl/jtag_tap_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_jtag_tap_ctrl.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl
// TAP controller for the JTAG core. It contains the 16-state TAP state machine,
// the 4-bit instruction register with its shift stage, and the 1-bit bypass
// register. It produces the instruction selects, the DR/IR strobes and the TDO
// multiplexer. The state machine and shift registers use the rising edge of TCK.
// The instruction register and the TDO launch flops use the falling edge of TCK.
module jtag_tap_ctrl #(
  parameter logic [3:0] IR_RESET   = 4'h5,
  parameter logic [3:0] IR_CAPTURE = 4'b0001
) (
  input  logic       TCK,
  input  logic       TRST,
  input  logic       TMS,
  input  logic       TDI,
  output logic       TDO,
  output logic       TDO_EN,
  output logic       TLR,
  output logic       RTI,
  output logic       CAPTUREDR,
  output logic       SHIFTDR,
  output logic       UPDATEDR,
  output logic       CAPTUREIR,
  output logic       SHIFTIR,
  output logic       UPDATEIR,
  output logic       BYPASS_SELECT,
  output logic       SAMPLE_SELECT,
  output logic       EXTEST_SELECT,
  output logic       INTEST_SELECT,
  output logic       RUNBIST_SELECT,
  output logic       CLAMP_SELECT,
  output logic       IDCODE_SELECT,
  output logic       USERCODE_SELECT,
  output logic       HIGHZ_SELECT,
  input  logic       BSR_TDO,
  input  logic       ID_REG_TDO,
  input  logic       USER_REG_TDO,
  output logic [3:0] IR_VALUE
);

  typedef enum logic [3:0] {
    S_TLR    = 4'd0,
    S_RTI    = 4'd1,
    S_SEL_DR = 4'd2,
    S_CAP_DR = 4'd3,
    S_SH_DR  = 4'd4,
    S_EX1_DR = 4'd5,
    S_PAU_DR = 4'd6,
    S_EX2_DR = 4'd7,
    S_UPD_DR = 4'd8,
    S_SEL_IR = 4'd9,
    S_CAP_IR = 4'd10,
    S_SH_IR  = 4'd11,
    S_EX1_IR = 4'd12,
    S_PAU_IR = 4'd13,
    S_EX2_IR = 4'd14,
    S_UPD_IR = 4'd15
  } tap_state_t;

  tap_state_t state_reg;
  logic [3:0] ir_sh_reg;
  logic [3:0] ir_reg;
  logic       bypass_reg;
  logic       ir_tdo_reg;
  logic       byp_tdo_reg;
  logic       tdo_en_reg;

  // One decode line per defined code. Codes 8..F fall through to BYPASS.
  logic [7:0] code_hit;
  logic       byp_path;
  logic       tdo_dr;

  // TAP state machine: advances on the rising edge of TCK and follows TMS
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      state_reg <= S_TLR;
    end else begin
      case (state_reg)
        S_TLR:    state_reg <= TMS ? S_TLR    : S_RTI;
        S_RTI:    state_reg <= TMS ? S_SEL_DR : S_RTI;
        S_SEL_DR: state_reg <= TMS ? S_SEL_IR : S_CAP_DR;
        S_CAP_DR: state_reg <= TMS ? S_EX1_DR : S_SH_DR;
        S_SH_DR:  state_reg <= TMS ? S_EX1_DR : S_SH_DR;
        S_EX1_DR: state_reg <= TMS ? S_UPD_DR : S_PAU_DR;
        S_PAU_DR: state_reg <= TMS ? S_EX2_DR : S_PAU_DR;
        S_EX2_DR: state_reg <= TMS ? S_UPD_DR : S_SH_DR;
        S_UPD_DR: state_reg <= TMS ? S_SEL_DR : S_RTI;
        S_SEL_IR: state_reg <= TMS ? S_TLR    : S_CAP_IR;
        S_CAP_IR: state_reg <= TMS ? S_EX1_IR : S_SH_IR;
        S_SH_IR:  state_reg <= TMS ? S_EX1_IR : S_SH_IR;
        S_EX1_IR: state_reg <= TMS ? S_UPD_IR : S_PAU_IR;
        S_PAU_IR: state_reg <= TMS ? S_EX2_IR : S_PAU_IR;
        S_EX2_IR: state_reg <= TMS ? S_UPD_IR : S_SH_IR;
        S_UPD_IR: state_reg <= TMS ? S_SEL_DR : S_RTI;
        default:  state_reg <= S_TLR;
      endcase
    end
  end

  // State strobes are decoded straight from the state register
  always_comb begin
    TLR       = (state_reg == S_TLR);
    RTI       = (state_reg == S_RTI);
    CAPTUREDR = (state_reg == S_CAP_DR);
    SHIFTDR   = (state_reg == S_SH_DR);
    UPDATEDR  = (state_reg == S_UPD_DR);
    CAPTUREIR = (state_reg == S_CAP_IR);
    SHIFTIR   = (state_reg == S_SH_IR);
    UPDATEIR  = (state_reg == S_UPD_IR);
  end

  // IR shift stage: capture a fixed pattern, shift LSB-first toward TDO
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_sh_reg <= 4'h0;
    end else if (state_reg == S_CAP_IR) begin
      ir_sh_reg <= IR_CAPTURE;
    end else if (state_reg == S_SH_IR) begin
      ir_sh_reg <= {TDI, ir_sh_reg[3:1]};
    end
  end

  // Bypass bit: active for BYPASS and for CLAMP/HIGHZ, which also use it as their DR
  always_ff @(posedge TCK or negedge TRST) begin
    if (!TRST) begin
      bypass_reg <= 1'b0;
    end else if (byp_path && (state_reg == S_CAP_DR)) begin
      bypass_reg <= 1'b0;
    end else if (byp_path && (state_reg == S_SH_DR)) begin
      bypass_reg <= TDI;
    end
  end

  // Instruction register updates on the falling edge. The new selects therefore
  // settle half a cycle before the FSM leaves UPD_IR.
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_reg <= IR_RESET;
    end else if (state_reg == S_UPD_IR) begin
      ir_reg <= ir_sh_reg;
    end else if (state_reg == S_TLR) begin
      ir_reg <= IR_RESET;
    end
  end

  // Falling-edge launch of serial data so the host can sample on the rising edge
  always_ff @(negedge TCK or negedge TRST) begin
    if (!TRST) begin
      ir_tdo_reg  <= 1'b0;
      byp_tdo_reg <= 1'b0;
      tdo_en_reg  <= 1'b0;
    end else begin
      ir_tdo_reg  <= ir_sh_reg[0];
      byp_tdo_reg <= bypass_reg;
      tdo_en_reg  <= (state_reg == S_SH_DR) || (state_reg == S_SH_IR);
    end
  end

  // One equality compare per defined instruction code 0..7
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_code
      assign code_hit[gi] = (ir_reg == 4'(gi));
    end
  endgenerate

  assign EXTEST_SELECT   = code_hit[0];
  assign SAMPLE_SELECT   = code_hit[1];
  assign INTEST_SELECT   = code_hit[2];
  assign RUNBIST_SELECT  = code_hit[3];
  assign CLAMP_SELECT    = code_hit[4];
  assign IDCODE_SELECT   = code_hit[5];
  assign USERCODE_SELECT = code_hit[6];
  assign HIGHZ_SELECT    = code_hit[7];
  assign BYPASS_SELECT   = ir_reg[3];

  assign byp_path = BYPASS_SELECT || CLAMP_SELECT || HIGHZ_SELECT;
  assign IR_VALUE = ir_reg;
  assign TDO_EN   = tdo_en_reg;

  // TDO mux: IR path while shifting IR, otherwise the DR chosen by the instruction
  always_comb begin
    tdo_dr = byp_tdo_reg;
    if (SAMPLE_SELECT || EXTEST_SELECT || INTEST_SELECT) begin
      tdo_dr = BSR_TDO;
    end else if (IDCODE_SELECT) begin
      tdo_dr = ID_REG_TDO;
    end else if (USERCODE_SELECT) begin
      tdo_dr = USER_REG_TDO;
    end
    TDO = 1'b0;
    if (tdo_en_reg) begin
      TDO = (state_reg == S_SH_IR) ? ir_tdo_reg : tdo_dr;
    end
  end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl. It acts as the JTAG host. Inputs are driven
// just after a falling edge, and outputs are observed 1 ns after each edge.
module tb_jtag_tap_ctrl;

  logic       TCK = 1'b0;
  logic       TRST = 1'b0;
  logic       TMS = 1'b1;
  logic       TDI = 1'b0;
  logic       TDO, TDO_EN;
  logic       TLR, RTI, CAPTUREDR, SHIFTDR, UPDATEDR, CAPTUREIR, SHIFTIR, UPDATEIR;
  logic       BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT, RUNBIST_SELECT;
  logic       CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT;
  logic       BSR_TDO = 1'b0;
  logic       ID_REG_TDO = 1'b0;
  logic       USER_REG_TDO = 1'b0;
  logic [3:0] IR_VALUE;

  int checks = 0;
  int fails  = 0;

  // Values seen 1 ns after the most recent rising edge
  logic       pos_tdo_en;
  logic [3:0] pos_ir;

  logic [7:0] strobes;
  logic [8:0] sels;
  assign strobes = {TLR, RTI, CAPTUREDR, SHIFTDR, UPDATEDR, CAPTUREIR, SHIFTIR, UPDATEIR};
  assign sels    = {BYPASS_SELECT, SAMPLE_SELECT, EXTEST_SELECT, INTEST_SELECT,
                    RUNBIST_SELECT, CLAMP_SELECT, IDCODE_SELECT, USERCODE_SELECT, HIGHZ_SELECT};

  jtag_tap_ctrl dut (
    .TCK(TCK), .TRST(TRST), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .TLR(TLR), .RTI(RTI), .CAPTUREDR(CAPTUREDR), .SHIFTDR(SHIFTDR), .UPDATEDR(UPDATEDR),
    .CAPTUREIR(CAPTUREIR), .SHIFTIR(SHIFTIR), .UPDATEIR(UPDATEIR),
    .BYPASS_SELECT(BYPASS_SELECT), .SAMPLE_SELECT(SAMPLE_SELECT),
    .EXTEST_SELECT(EXTEST_SELECT), .INTEST_SELECT(INTEST_SELECT),
    .RUNBIST_SELECT(RUNBIST_SELECT), .CLAMP_SELECT(CLAMP_SELECT),
    .IDCODE_SELECT(IDCODE_SELECT), .USERCODE_SELECT(USERCODE_SELECT),
    .HIGHZ_SELECT(HIGHZ_SELECT), .BSR_TDO(BSR_TDO), .ID_REG_TDO(ID_REG_TDO),
    .USER_REG_TDO(USER_REG_TDO), .IR_VALUE(IR_VALUE)
  );

  always #10 TCK = ~TCK;

  // Watchdog so the run can never hang
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One TCK cycle: drive TMS/TDI, then let the rising edge and the falling edge pass
  task automatic step(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK); #1;
    pos_tdo_en = TDO_EN;
    pos_ir     = IR_VALUE;
    @(negedge TCK); #1;
  endtask

  task automatic five_ones();
    repeat (5) step(1'b1, 1'b0);
  endtask

  // Full IR scan starting from RTI. It ends back in RTI with the code loaded.
  task automatic ir_scan(input logic [3:0] code);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(i == 3, code[i]);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  // Expected one-hot, ordered {BYPASS,SAMPLE,EXTEST,INTEST,RUNBIST,CLAMP,IDCODE,USERCODE,HIGHZ}
  function automatic logic [8:0] exp_sel(input logic [3:0] c);
    case (c)
      4'h0:    return 9'b001_000_000;
      4'h1:    return 9'b010_000_000;
      4'h2:    return 9'b000_100_000;
      4'h3:    return 9'b000_010_000;
      4'h4:    return 9'b000_001_000;
      4'h5:    return 9'b000_000_100;
      4'h6:    return 9'b000_000_010;
      4'h7:    return 9'b000_000_001;
      default: return 9'b100_000_000;
    endcase
  endfunction

  // TMS paths from TLR (bit 0 first) with the strobe vector expected at the end
  logic [7:0] path_bits [20] = '{8'h00, 8'h00, 8'h02, 8'h02, 8'h02, 8'h0A, 8'h0A, 8'h2A,
                                 8'h1A, 8'h06, 8'h06, 8'h06, 8'h16, 8'h16, 8'h56, 8'h36,
                                 8'h2A, 8'h56, 8'h3A, 8'h36};
  int         path_len  [20] = '{0, 1, 2, 3, 4, 4, 5, 6, 5, 3, 4, 5, 5, 6, 7, 6, 7, 8, 7, 7};
  logic [7:0] path_exp  [20] = '{8'h80, 8'h40, 8'h00, 8'h20, 8'h10, 8'h00, 8'h00, 8'h00,
                                 8'h08, 8'h00, 8'h04, 8'h02, 8'h00, 8'h00, 8'h00, 8'h01,
                                 8'h10, 8'h02, 8'h20, 8'h40};

  logic [3:0] dec_codes [8] = '{4'h0, 4'h2, 4'h3, 4'h4, 4'h7, 4'h8, 4'hE, 4'hF};

  logic [3:0] cap_pat;
  logic [3:0] byp_pat;
  logic [7:0] user_pat;
  logic [7:0] pb;

  initial begin
    cap_pat  = 4'b0001;
    byp_pat  = 4'b1101;
    user_pat = 8'hA7;

    // Reset held low across a few edges
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("reset_strobes", 16'(strobes), 16'h80);
    check("reset_ir", 16'(IR_VALUE), 16'h5);
    check("reset_sel", 16'(sels), 16'(9'b000_000_100));
    check("reset_tdo_en", 16'(TDO_EN), 16'h0);
    check("reset_tdo", 16'(TDO), 16'h0);
    TRST = 1'b1;

    // TMS 0,1,1,0,0 into SH_IR. The captured pattern returns LSB first.
    step(1'b0, 1'b0);
    check("rti", 16'(strobes), 16'h40);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("cap_ir", 16'(strobes), 16'h04);
    step(1'b0, 1'b0);
    check("sh_ir", 16'(strobes), 16'h02);
    check("sh_ir_tdo_en", 16'(TDO_EN), 16'h1);
    check("ir_tdo_bit0", 16'(TDO), 16'(cap_pat[0]));
    // Shift in SAMPLE (4'h1) LSB first while the capture bits come out
    step(1'b0, 1'b1);
    check("ir_tdo_bit1", 16'(TDO), 16'(cap_pat[1]));
    step(1'b0, 1'b0);
    check("ir_tdo_bit2", 16'(TDO), 16'(cap_pat[2]));
    step(1'b0, 1'b0);
    check("ir_tdo_bit3", 16'(TDO), 16'(cap_pat[3]));
    step(1'b1, 1'b0);
    check("ex1_ir_tdo_en", 16'(TDO_EN), 16'h0);
    step(1'b1, 1'b0);
    check("upd_ir", 16'(strobes), 16'h01);
    check("upd_ir_old_ir_at_pos", 16'(pos_ir), 16'h5);
    check("upd_ir_new_ir_at_neg", 16'(IR_VALUE), 16'h1);
    check("sample_sel", 16'(sels), 16'(exp_sel(4'h1)));
    step(1'b0, 1'b0);

    // SAMPLE: DR shift routes BSR_TDO
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("cap_dr", 16'(strobes), 16'h20);
    BSR_TDO = 1'b1;
    step(1'b0, 1'b0);
    check("sh_dr", 16'(strobes), 16'h10);
    check("bsr_tdo_1", 16'(TDO), 16'h1);
    BSR_TDO = 1'b0;
    USER_REG_TDO = 1'b1;
    step(1'b0, 1'b0);
    check("bsr_tdo_0", 16'(TDO), 16'h0);
    USER_REG_TDO = 1'b0;
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("upd_dr", 16'(strobes), 16'h08);
    step(1'b0, 1'b0);

    // Undefined code 4'hB gives BYPASS. Captured 0 first, then TDI echoed.
    ir_scan(4'hB);
    check("ir_b_value", 16'(IR_VALUE), 16'hB);
    check("ir_b_sel", 16'(sels), 16'(9'b100_000_000));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("byp_captured_0", 16'(TDO), 16'h0);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, byp_pat[i]);
      check($sformatf("byp_bit%0d", i), 16'(TDO), 16'(byp_pat[i]));
    end
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Instruction decode across defined codes and the undefined range ends
    for (int k = 0; k < 8; k++) begin
      ir_scan(dec_codes[k]);
      check($sformatf("dec_ir_%0h", dec_codes[k]), 16'(IR_VALUE), 16'(dec_codes[k]));
      check($sformatf("dec_sel_%0h", dec_codes[k]), 16'(sels), 16'(exp_sel(dec_codes[k])));
    end

    // USERCODE: 8-bit DR stream. TDO_EN drops at the falling edge after SH_DR.
    ir_scan(4'h6);
    check("user_sel", 16'(sels), 16'(9'b000_000_010));
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    USER_REG_TDO = user_pat[0];
    step(1'b0, 1'b0);
    check("user_bit0", 16'(TDO), 16'(user_pat[0]));
    for (int i = 1; i < 8; i++) begin
      USER_REG_TDO = user_pat[i];
      step(1'b0, 1'b0);
      check($sformatf("user_bit%0d", i), 16'(TDO), 16'(user_pat[i]));
    end
    USER_REG_TDO = 1'b0;
    step(1'b1, 1'b0);
    check("tdo_en_held_at_pos", 16'(pos_tdo_en), 16'h1);
    check("tdo_en_fell_at_neg", 16'(TDO_EN), 16'h0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);

    // Asynchronous reset in the middle of an IR shift
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    TRST = 1'b0;
    #2;
    check("trst_strobes", 16'(strobes), 16'h80);
    check("trst_ir", 16'(IR_VALUE), 16'h5);
    check("trst_sel", 16'(sels), 16'(9'b000_000_100));
    check("trst_tdo_en", 16'(TDO_EN), 16'h0);
    check("trst_tdo", 16'(TDO), 16'h0);
    #2;
    TRST = 1'b1;
    step(1'b1, 1'b0);
    check("post_trst_tlr", 16'(strobes), 16'h80);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("post_trst_fresh_capture", 16'(TDO), 16'h1);
    five_ones();

    // IDCODE after reset routes ID_REG_TDO
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    ID_REG_TDO = 1'b1;
    step(1'b0, 1'b0);
    check("id_tdo_1", 16'(TDO), 16'h1);
    ID_REG_TDO = 1'b0;
    BSR_TDO = 1'b1;
    step(1'b0, 1'b0);
    check("id_tdo_0", 16'(TDO), 16'h0);
    BSR_TDO = 1'b0;

    // Reach every state, check its strobes, then five TMS=1 edges back to TLR
    five_ones();
    for (int p = 0; p < 20; p++) begin
      pb = path_bits[p];
      for (int b = 0; b < path_len[p]; b++) step(pb[b], 1'b0);
      check($sformatf("path%0d_strobes", p), 16'(strobes), 16'(path_exp[p]));
      five_ones();
      check($sformatf("path%0d_tlr", p), 16'(strobes), 16'h80);
      check($sformatf("path%0d_ir", p), 16'(IR_VALUE), 16'h5);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
